mc_decoder: RTL and testbench
=============================

MC_DECODER -- requirements
Module: mc_decoder

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 4, meaning ALU cycles a MUL occupies (legal 1..16).
REQ-002 SHALL have parameter ALUCW, default 3, meaning ALUControl width (legal >=3, upper bits zero).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-005 SHALL have ports Op  input  2, Funct  input  6, Rd  input  4, Mul  input  4, meaning instruction fields [27:26], [25:20], [15:12], [7:4].
REQ-006 SHALL have outputs IRWrite, AdrSrc, NextPC, PCS, RegW, MemW, NoWrite  output  1 each, meaning unconditioned control strobes (condition unit gates RegW/MemW/FlagW/PCS).
REQ-007 SHALL have outputs ALUSrcA  output  1, ALUSrcB  output  2, ResultSrc  output  2, ImmSrc  output  2, RegSrc  output  2, FlagW  output  2, ALUControl  output  ALUCW.
REQ-008 SHALL have output Busy  output  1, meaning FSM not in FETCH.

Function
REQ-009 SHALL implement FSM states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, MULWAIT, ALUWB, BRANCH.
REQ-010 Transitions SHALL be: FETCH->DECODE; DECODE->MEMADR (Op=01), EXECR (Op=00, Funct[5]=0), EXECI (Op=00, Funct[5]=1), BRANCH (Op=10), FETCH (Op=11, unimplemented).
REQ-011 MEMADR SHALL go to MEMRD if Funct[0]=1 else MEMWR; MEMRD->MEMWB; MEMWB, MEMWR, ALUWB, BRANCH->FETCH.
REQ-012 EXECR SHALL go to MULWAIT when MUL (Funct[4:1]=0000, Mul=1001) and MUL_CYCLES>1, else to ALUWB; EXECI->ALUWB.
REQ-013 EXECR/EXECI SHALL go to FETCH instead of ALUWB when NoWrite=1 (CMP).
REQ-014 MULWAIT SHALL load counter to MUL_CYCLES-2 on entry, decrement each cycle, exit to ALUWB the cycle after count reaches 0; MUL total execute occupancy = MUL_CYCLES cycles.
REQ-015 Per-state strobes (unlisted = 0): FETCH IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10; DECODE ALUSrcA=1, ALUSrcB=10, ResultSrc=10; MEMADR ALUSrcB=01; MEMRD AdrSrc=1; MEMWB ResultSrc=01, RegW=1; MEMWR AdrSrc=1, MemW=1; EXECR ALUSrcB=00; EXECI ALUSrcB=01; MULWAIT ALUSrcB=00; ALUWB RegW=1; BRANCH ALUSrcB=01, ResultSrc=10.
REQ-016 ALU decode SHALL be active in EXECR, EXECI, MULWAIT; map Funct[4:1]: 0100 ADD=000, 0010 SUB=001, 0000 AND=010 or MUL=100 when Mul[3]=1, 1100 ORR=011, 1010 CMP=001 with NoWrite=1, 0111=110, 1101 MOV=101; other codes ALUControl=0, NoWrite=1 (no writeback).
REQ-017 Outside ALU-decode states ALUControl SHALL be 000 (ADD), NoWrite=0, FlagW=00.
REQ-018 FlagW SHALL be asserted only in the last execute cycle (EXECR/EXECI, or final MULWAIT cycle): FlagW[1]=Funct[0]; FlagW[0]=Funct[0] & (ALUControl is 000 or 001).
REQ-019 ImmSrc/RegSrc SHALL be combinational on Op every cycle: Op=00 ImmSrc=00 RegSrc=00; Op=01 ImmSrc=01, RegSrc=10 (STR) or 00 (LDR); Op=10 ImmSrc=10 RegSrc=01; Op=11 all 0.
REQ-020 PCS SHALL be (Rd=1111 & RegW) | (state=BRANCH).
REQ-021 Instruction fields SHALL be sampled every cycle; bench/datapath holds them stable from DECODE until return to FETCH.

Reset
REQ-022 reset=0 SHALL asynchronously force state FETCH and MUL counter 0; outputs take FETCH values from REQ-015 while reset is held.
REQ-023 Reset asserted mid-instruction (any state incl. MULWAIT) SHALL abort it with no further RegW/MemW/FlagW; first post-release edge goes FETCH->DECODE.

Verification
REQ-024 ADD reg, S=1 (Op=00, Funct=001001, Rd=0011): states FETCH,DECODE,EXECR,ALUWB; ALUControl=000, FlagW=11 in EXECR, RegW=1 in ALUWB, PCS=0.
REQ-025 LDR then STR (Op=01, Funct[0]=1 / 0): LDR 5 cycles with RegW in MEMWB, ResultSrc=01; STR 4 cycles with MemW=1, AdrSrc=1 in MEMWR.
REQ-026 MUL with MUL_CYCLES=4 (Funct[4:1]=0000, Mul=1001): EXECR, 3 MULWAIT cycles, ALUWB; ALUControl=100 throughout; repeat with MUL_CYCLES=1: no MULWAIT.
REQ-027 CMP (Funct=010101): EXECR->FETCH, NoWrite=1, FlagW=11, no RegW; B (Op=10): BRANCH with PCS=1, then FETCH.
REQ-028 reset pulsed low during MULWAIT second cycle: state FETCH asynchronously, no RegW/FlagW issued; Op=11 after reset: DECODE->FETCH, no strobes.

Source files
------------

// File: rtl/mc_decoder_if.sv
// mc_decoder_if: instruction fields toward the decoder and unconditioned control strobes back to the datapath.
interface mc_decoder_if #(parameter int ALUCW = 3);
    logic [1:0]       Op;
    logic [5:0]       Funct;
    logic [3:0]       Rd;
    logic [3:0]       Mul;
    logic             IRWrite, AdrSrc, NextPC, PCS, RegW, MemW, NoWrite, ALUSrcA, Busy;
    logic [1:0]       ALUSrcB, ResultSrc, ImmSrc, RegSrc, FlagW;
    logic [ALUCW-1:0] ALUControl;
    modport master (
        output Op, Funct, Rd, Mul,
        input  IRWrite, AdrSrc, NextPC, PCS, RegW, MemW, NoWrite, ALUSrcA, Busy,
        input  ALUSrcB, ResultSrc, ImmSrc, RegSrc, FlagW, ALUControl
    );
    modport slave (
        input  Op, Funct, Rd, Mul,
        output IRWrite, AdrSrc, NextPC, PCS, RegW, MemW, NoWrite, ALUSrcA, Busy,
        output ALUSrcB, ResultSrc, ImmSrc, RegSrc, FlagW, ALUControl
    );
endinterface

// File: rtl/mc_decoder.sv
// mc_decoder: multicycle control FSM with ALU decode and a MUL occupancy counter.
module mc_decoder #(
    parameter int MUL_CYCLES = 4,
    parameter int ALUCW      = 3
) (
    input  logic         clk,
    input  logic         reset,
    mc_decoder_if.slave  bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, MULWAIT, ALUWB, BRANCH
    } state_t;
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] alu;
    logic       nowr, dec_act, is_mul, last_exec, regw;
    assign dec_act = state_q inside {EXECR, EXECI, MULWAIT};
    assign is_mul  = (bus.Funct[4:1] == 4'b0000) && (bus.Mul == 4'b1001);
    always_comb begin
        alu  = 3'b000;
        nowr = 1'b0;
        if (dec_act)
            case (bus.Funct[4:1])
                4'b0100: alu = 3'b000;
                4'b0010: alu = 3'b001;
                4'b0000: alu = bus.Mul[3] ? 3'b100 : 3'b010;
                4'b1100: alu = 3'b011;
                4'b1010: begin alu = 3'b001; nowr = 1'b1; end
                4'b0111: alu = 3'b110;
                4'b1101: alu = 3'b101;
                default: nowr = 1'b1;
            endcase
    end
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_exec     = 1'b0;
        regw          = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.NextPC    = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.MemW      = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = 2'b00;
        bus.ResultSrc = 2'b00;
        case (state_q)
            FETCH: begin
                bus.IRWrite   = 1'b1;
                bus.NextPC    = 1'b1;
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                state_d       = DECODE;
            end
            DECODE: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                state_d = bus.Op == 2'b01 ? MEMADR :
                          bus.Op == 2'b00 ? (bus.Funct[5] ? EXECI : EXECR) :
                          bus.Op == 2'b10 ? BRANCH : FETCH;
            end
            MEMADR: begin
                bus.ALUSrcB = 2'b01;
                state_d     = bus.Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                bus.AdrSrc = 1'b1;
                state_d    = MEMWB;
            end
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                regw          = 1'b1;
                state_d       = FETCH;
            end
            MEMWR: begin
                bus.AdrSrc = 1'b1;
                bus.MemW   = 1'b1;
                state_d    = FETCH;
            end
            EXECR:
                // Counter is preloaded so EXECR plus the MULWAIT cycles total MUL_CYCLES.
                if (is_mul && MUL_CYCLES > 1) begin
                    state_d = MULWAIT;
                    cnt_d   = 4'(MUL_CYCLES - 2);
                end else begin
                    last_exec = 1'b1;
                    state_d   = nowr ? FETCH : ALUWB;
                end
            EXECI: begin
                bus.ALUSrcB = 2'b01;
                last_exec   = 1'b1;
                state_d     = nowr ? FETCH : ALUWB;
            end
            MULWAIT:
                if (cnt_q == 4'd0) begin
                    last_exec = 1'b1;
                    state_d   = ALUWB;
                end else
                    cnt_d = cnt_q - 4'd1;
            ALUWB: begin
                regw    = 1'b1;
                state_d = FETCH;
            end
            BRANCH: begin
                bus.ALUSrcB   = 2'b01;
                bus.ResultSrc = 2'b10;
                state_d       = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q <= FETCH;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    assign bus.RegW       = regw;
    assign bus.NoWrite    = nowr;
    assign bus.ALUControl = ALUCW'(alu);
    assign bus.FlagW      = last_exec ? {bus.Funct[0], bus.Funct[0] & (alu[2:1] == 2'b00)} : 2'b00;
    assign bus.PCS        = ((bus.Rd == 4'hF) & regw) | (state_q == BRANCH);
    assign bus.Busy       = state_q != FETCH;
    assign bus.ImmSrc     = bus.Op == 2'b11 ? 2'b00 : bus.Op;
    assign bus.RegSrc     = bus.Op == 2'b01 ? (bus.Funct[0] ? 2'b00 : 2'b10) :
                            bus.Op == 2'b10 ? 2'b01 : 2'b00;
endmodule

// File: tb/tb_mc_decoder.sv
// tb_mc_decoder: directed instruction sequences; per-cycle expected strobes queued and compared on the falling edge.
module tb_mc_decoder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic sel = 1'b0;
    always #5 clk = ~clk;
    mc_decoder_if #(.ALUCW(3)) b4();
    mc_decoder_if #(.ALUCW(3)) b1();
    mc_decoder #(.MUL_CYCLES(4), .ALUCW(3)) d4 (.clk(clk), .reset(reset), .bus(b4.slave));
    mc_decoder #(.MUL_CYCLES(1), .ALUCW(3)) d1 (.clk(clk), .reset(reset), .bus(b1.slave));
    typedef struct {
        string       tag;
        logic [17:0] v;
    } exp_t;
    exp_t sb[$];
    int total = 0;
    int bad = 0;
    logic [17:0] o4, o1;
    logic [17:0] F, D;
    assign o4 = {b4.Busy, b4.IRWrite, b4.NextPC, b4.AdrSrc, b4.RegW, b4.MemW, b4.NoWrite, b4.PCS,
                 b4.ALUSrcA, b4.ALUSrcB, b4.ResultSrc, b4.FlagW, b4.ALUControl};
    assign o1 = {b1.Busy, b1.IRWrite, b1.NextPC, b1.AdrSrc, b1.RegW, b1.MemW, b1.NoWrite, b1.PCS,
                 b1.ALUSrcA, b1.ALUSrcB, b1.ResultSrc, b1.FlagW, b1.ALUControl};
    function automatic logic [17:0] v(input logic busy, irw, npc, adr, rw, mw, nw, pcs, sa,
                                      input logic [1:0] srcb, rs, fw, input logic [2:0] alu);
        return {busy, irw, npc, adr, rw, mw, nw, pcs, sa, srcb, rs, fw, alu};
    endfunction
    task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] e);
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask
    task automatic push(input string tag, input logic [17:0] e);
        sb.push_back('{tag, e});
    endtask
    task automatic drain;
        exp_t x;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            #1 chk(x.tag, sel ? o1 : o4, x.v);
            @(negedge clk);
        end
    endtask
    task automatic set_ins(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd, mul);
        b4.Op = op; b4.Funct = funct; b4.Rd = rd; b4.Mul = mul;
        b1.Op = op; b1.Funct = funct; b1.Rd = rd; b1.Mul = mul;
    endtask
    task automatic chk_src(input string tag, input logic [1:0] imm, reg_src);
        #1 chk(tag, {14'd0, b4.ImmSrc, b4.RegSrc}, {14'd0, imm, reg_src});
    endtask
    initial begin
        F = v(0, 1, 1, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 3'b000);
        D = v(1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 3'b000);
        set_ins(2'b00, 6'b000000, 4'h0, 4'h0);
        repeat (2) @(negedge clk);
        #1 chk("reset_hold_m4", o4, F);
        chk("reset_hold_m1", o1, F);
        @(negedge clk);
        reset = 1'b1;
        // ADD r3, S=1
        set_ins(2'b00, 6'b001001, 4'h3, 4'h0);
        chk_src("add_src", 2'b00, 2'b00);
        push("add_fetch", F);
        push("add_decode", D);
        push("add_execr", v(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 3'b000));
        push("add_aluwb", v(1, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000));
        drain();
        // LDR into r15: PCS follows RegW in MEMWB
        set_ins(2'b01, 6'b011001, 4'hF, 4'h0);
        chk_src("ldr_src", 2'b01, 2'b00);
        push("ldr_fetch", F);
        push("ldr_decode", D);
        push("ldr_memadr", v(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000));
        push("ldr_memrd", v(1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000));
        push("ldr_memwb", v(1, 0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b01, 2'b00, 3'b000));
        drain();
        set_ins(2'b01, 6'b011000, 4'h4, 4'h0);
        chk_src("str_src", 2'b01, 2'b10);
        push("str_fetch", F);
        push("str_decode", D);
        push("str_memadr", v(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000));
        push("str_memwr", v(1, 0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000));
        drain();
        // MUL S=1 with four execute cycles; flags only in the last one
        set_ins(2'b00, 6'b000001, 4'h2, 4'b1001);
        push("mul4_fetch", F);
        push("mul4_decode", D);
        push("mul4_execr", v(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b100));
        push("mul4_wait1", v(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b100));
        push("mul4_wait2", v(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b100));
        push("mul4_wait3", v(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 3'b100));
        push("mul4_aluwb", v(1, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000));
        drain();
        set_ins(2'b00, 6'b010101, 4'h0, 4'h0);
        push("cmp_fetch", F);
        push("cmp_decode", D);
        push("cmp_execr", v(1, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b11, 3'b001));
        drain();
        set_ins(2'b10, 6'b000000, 4'h0, 4'h0);
        chk_src("b_src", 2'b10, 2'b01);
        push("b_fetch", F);
        push("b_decode", D);
        push("b_branch", v(1, 0, 0, 0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 3'b000));
        drain();
        // MUL aborted by reset in its second MULWAIT cycle
        set_ins(2'b00, 6'b000001, 4'h2, 4'b1001);
        push("abort_fetch", F);
        push("abort_decode", D);
        push("abort_execr", v(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b100));
        push("abort_wait1", v(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b100));
        drain();
        #1 chk("abort_wait2", o4, v(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b100));
        reset = 1'b0;
        #1 chk("async_reset", o4, F);
        @(posedge clk);
        #1 chk("reset_held_edge", o4, F);
        @(negedge clk);
        reset = 1'b1;
        set_ins(2'b11, 6'b000000, 4'h0, 4'h0);
        chk_src("op11_src", 2'b00, 2'b00);
        push("op11_fetch", F);
        push("op11_decode", D);
        push("op11_return", F);
        drain();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        sel = 1'b1;
        // Single-cycle MUL: no MULWAIT, flags in EXECR
        set_ins(2'b00, 6'b000001, 4'h2, 4'b1001);
        push("mul1_fetch", F);
        push("mul1_decode", D);
        push("mul1_execr", v(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 3'b100));
        push("mul1_aluwb", v(1, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000));
        push("mul1_return", F);
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
